serial_to_parallel: RTL and testbench
=====================================

# serial_to_parallel

Collects a stream of DATA_WIDTH-bit words arriving one per handshake into groups of N and presents each group as one parallel vector with a valid/ready handshake. It sits directly downstream of the parallel-to-serial stage and restores the original lane order: the first word of a group lands in lane 0. One completed group can be held at the output while the next group accumulates, so backpressure only stalls the input on a group's closing word.

## Interface
- DATA_WIDTH, 32, width of one word
- N, 2, words per group / output lanes (N >= 1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- valid_in  in  1  data_in valid
- data_in  in  DATA_WIDTH  serial word
- ready_in  out  1  block accepts data_in this cycle
- data_out  out  DATA_WIDTH x [0:N-1]  parallel group, lane k = k-th word of group
- valid_out  out  1  data_out holds a complete group
- ready_out  in  1  downstream accepts data_out
- last_in  in  1  closes current group early (only with SERIAL_TO_PARALLEL_LAST_EN)
- lanes_out  out  $clog2(N+1)  number of valid lanes in data_out (only with SERIAL_TO_PARALLEL_LAST_EN)

## Operation
- State: accumulator acc[0:N-2], counter count in 0..N-1, output register data_out/valid_out.
- accept_in = valid_in && ready_in; accept_out = valid_out && ready_out; out_free = !valid_out || ready_out.
- ready_in = (count != N-1) || out_free. Combinational, independent of valid_in (without macro).
- accept_in with count < N-1: acc[count] <= data_in; count <= count+1.
- accept_in with count == N-1 (closing word): data_out <= {acc[0:N-2], data_in}; valid_out <= 1; count <= 0.
- accept_out without a closing word the same cycle: valid_out <= 0; data_out retains last value.
- accept_out and closing word same cycle: new group loaded, valid_out stays 1 (no bubble).
- data_out and valid_out stable while valid_out && !ready_out.
- N == 1: count constant 0; block is a single valid/ready register slice, ready_in = out_free.
- No data reordering, no drops, no duplication; every accepted word appears in exactly one output group.

## Timing
- Reset: valid_out=0, data_out all lanes 0, count=0, acc all 0, lanes_out=0; ready_in=1 on first cycle after reset.
- Latency: closing word accepted at edge t -> valid_out=1 and group on data_out after edge t.
- Full throughput: with ready_out held 1, one word accepted every cycle, one group emitted every N cycles.
- Backpressure: closing word stalls (ready_in=0) only while valid_out=1 and ready_out=0; non-closing words keep being accepted.
- rst mid-group or with valid_out=1: partial group and held group discarded, all state returns to reset values next cycle.
- valid_in low mid-group: count and acc hold indefinitely.

## Configuration
- SERIAL_TO_PARALLEL_LAST_EN defined: last_in and lanes_out exist. Accepting a word with last_in=1 closes the group at any count: word goes to lane count, lanes count+1..N-1 zero-filled, lanes_out = count+1, count <= 0. ready_in = ((count != N-1) && !(valid_in && last_in)) || out_free. Full groups give lanes_out = N.
- Not defined: ports absent, groups always exactly N words, behaviour as in Operation.

## Structure
- Shared package utils_pkg: function cnt_width(N) returning $clog2(N) with minimum 1, and lane-count width $clog2(N+1); used by counter and lanes_out.
- One sub-module s2p_out_slot: parameterised valid/ready output register (load, hold, clear on accept_out), also instantiated for N == 1.

## Test plan
- N=4, DW=8, ready_out=1, words 0x11,0x22,0x33,0x44 back-to-back -> valid_out one cycle after 0x44, data_out={0x11,0x22,0x33,0x44}, ready_in never low.
- N=4, ready_out=0, send 8 words 0x01..0x08 -> first group held, words 0x05..0x07 accepted, ready_in=0 with 0x08 presented; raise ready_out -> group 2 {0x05..0x08} follows with no bubble.
- N=2, continuous stream 0..15 with random ready_out -> output groups {0,1},{2,3},...,{14,15} in order, none lost.
- N=3, two words accepted then rst -> valid_out=0, count=0; next three words 0xA,0xB,0xC yield {0xA,0xB,0xC}.
- N=1, random valid_in/ready_out -> data_out equals each input word one cycle later, stable under backpressure.
- LAST_EN, N=4: words 0x10,0x20 with last_in on 0x20 -> data_out={0x10,0x20,0,0}, lanes_out=2; then 4 words -> lanes_out=4.

Source files
------------

// File: rtl/utils_pkg.sv
// Shared width helpers for counter and lane-count fields.
package utils_pkg;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned lanes_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/s2p_out_slot.sv
// Single-entry valid/ready output register: load, hold under backpressure, clear on accept.
module s2p_out_slot #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready_out,
  output logic         valid_out,
  output logic [W-1:0] data_out
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && ready_out) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;

endmodule

// File: rtl/serial_to_parallel.sv
// Gathers N serial words into one parallel group (lane 0 = first word).
// Optional early group close via last_in/lanes_out when SERIAL_TO_PARALLEL_LAST_EN is defined.
module serial_to_parallel
  import utils_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N          = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_in,
  input  logic [DATA_WIDTH-1:0]           data_in,
  output logic                            ready_in,
  output logic [0:N-1][DATA_WIDTH-1:0]    data_out,
  output logic                            valid_out,
  input  logic                            ready_out
`ifdef SERIAL_TO_PARALLEL_LAST_EN
  ,
  input  logic                            last_in,
  output logic [lanes_width(N)-1:0]       lanes_out
`endif
);

  localparam int unsigned CW = cnt_width(N);
  localparam int unsigned GW = N * DATA_WIDTH;
`ifdef SERIAL_TO_PARALLEL_LAST_EN
  localparam int unsigned LW = lanes_width(N);
  localparam int unsigned SW = GW + LW;
`else
  localparam int unsigned SW = GW;
`endif

  logic [CW-1:0]                  count_q, count_d;
  logic                           at_end, closing, accept_in, load;
  logic [0:N-1][DATA_WIDTH-1:0]   group;
  logic [SW-1:0]                  slot_d, slot_q;

  always_comb begin
    at_end = (count_q == CW'(N - 1));
`ifdef SERIAL_TO_PARALLEL_LAST_EN
    closing  = at_end || last_in;
    ready_in = (!at_end && !(valid_in && last_in)) || !valid_out || ready_out;
`else
    closing  = at_end;
    ready_in = !at_end || !valid_out || ready_out;
`endif
    accept_in = valid_in && ready_in;
    load      = accept_in && closing;
    count_d   = count_q;
    if (accept_in) count_d = closing ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  if (N > 1) begin : g_acc
    logic [0:N-2][DATA_WIDTH-1:0] acc_q, acc_d;

    always_comb begin
      acc_d = acc_q;
      if (accept_in && !closing) begin
        for (int unsigned k = 0; k < N - 1; k++) begin
          if (count_q == CW'(k)) acc_d[k] = data_in;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
    end

    // Lanes past the closing word are zeroed, which covers early-closed groups too.
    always_comb begin
      group = '0;
      for (int unsigned k = 0; k < N - 1; k++) begin
        if (CW'(k) < count_q)       group[k] = acc_q[k];
        else if (CW'(k) == count_q) group[k] = data_in;
      end
      if (count_q == CW'(N - 1)) group[N-1] = data_in;
    end
  end else begin : g_single
    always_comb group = data_in;
  end

  always_comb begin
`ifdef SERIAL_TO_PARALLEL_LAST_EN
    slot_d = {LW'(count_q) + LW'(1), group};
`else
    slot_d = group;
`endif
  end

  s2p_out_slot #(.W(SW)) u_out_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(slot_d),
    .ready_out(ready_out),
    .valid_out(valid_out),
    .data_out (slot_q)
  );

  always_comb begin
`ifdef SERIAL_TO_PARALLEL_LAST_EN
    {lanes_out, data_out} = slot_q;
`else
    data_out = slot_q;
`endif
  end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed + random bench for serial_to_parallel at N=1..4, checked against a group-queue model.
module tb_serial_to_parallel;

  logic clk = 1'b0;
  logic rst;
  logic       vin  [1:4];
  logic       rout [1:4];
  logic [7:0] din  [1:4];
  logic       rin  [1:4];
  logic       vout [1:4];
  logic [7:0] lane [1:4][0:3];
  logic [2:0] lanes[1:4];
`ifdef SERIAL_TO_PARALLEL_LAST_EN
  logic       lin  [1:4];
`endif

  int checks = 0;
  int errors = 0;
  int groups = 0;

  logic [31:0] expq [1:4][$];
  int          expl [1:4][$];
  logic [7:0]  part [1:4][$];

  always #5 clk = ~clk;

  for (genvar n = 1; n <= 4; n++) begin : g_dut
    logic [0:n-1][7:0] d;
`ifdef SERIAL_TO_PARALLEL_LAST_EN
    logic [$clog2(n+1)-1:0] lo;
    assign lanes[n] = 3'(lo);
`else
    assign lanes[n] = '0;
`endif
    serial_to_parallel #(.DATA_WIDTH(8), .N(n)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .valid_in (vin[n]),
      .data_in  (din[n]),
      .ready_in (rin[n]),
      .data_out (d),
      .valid_out(vout[n]),
      .ready_out(rout[n])
`ifdef SERIAL_TO_PARALLEL_LAST_EN
      ,
      .last_in  (lin[n]),
      .lanes_out(lo)
`endif
    );
    for (genvar k = 0; k < 4; k++) begin : g_lane
      if (k < n) begin : g_on
        assign lane[n][k] = d[k];
      end else begin : g_off
        assign lane[n][k] = '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] lanes_of(input int n);
    return {lane[n][3], lane[n][2], lane[n][1], lane[n][0]};
  endfunction

  // One cycle on DUT n: drive at negedge, check, update model from the handshakes.
  task automatic step(input int n, input logic v, input logic [7:0] d, input logic last,
                      input logic r, output logic took);
    logic        rdy_exp, last_eff;
    logic [31:0] g;
    vin[n] = v; din[n] = d; rout[n] = r;
`ifdef SERIAL_TO_PARALLEL_LAST_EN
    lin[n] = last; last_eff = last;
`else
    last_eff = 1'b0;
`endif
    #1;
    rdy_exp = ((part[n].size() != n - 1) && !(v && last_eff)) || (expq[n].size() == 0) || r;
    chk($sformatf("ready_in_n%0d", n), 32'(rin[n]), 32'(rdy_exp));
    chk($sformatf("valid_out_n%0d", n), 32'(vout[n]), 32'(expq[n].size() != 0));
    if (expq[n].size() != 0) begin
      chk($sformatf("data_out_n%0d", n), lanes_of(n), expq[n][0]);
`ifdef SERIAL_TO_PARALLEL_LAST_EN
      chk($sformatf("lanes_out_n%0d", n), 32'(lanes[n]), 32'(expl[n][0]));
`endif
      if (vout[n] && r) begin
        void'(expq[n].pop_front());
        void'(expl[n].pop_front());
        groups++;
      end
    end
    took = v && rin[n];
    if (took) begin
      part[n].push_back(d);
      if (part[n].size() == n || last_eff) begin
        g = '0;
        for (int k = 0; k < part[n].size(); k++) g[8*k +: 8] = part[n][k];
        expq[n].push_back(g);
        expl[n].push_back(part[n].size());
        part[n].delete();
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      vin[n] = 1'b0; rout[n] = 1'b0; din[n] = '0;
`ifdef SERIAL_TO_PARALLEL_LAST_EN
      lin[n] = 1'b0;
`endif
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      expq[n].delete(); expl[n].delete(); part[n].delete();
    end
    #1;
    for (int n = 1; n <= 4; n++) begin
      chk($sformatf("rst_valid_n%0d", n), 32'(vout[n]), 32'd0);
      chk($sformatf("rst_ready_n%0d", n), 32'(rin[n]), 32'd1);
      chk($sformatf("rst_data_n%0d", n), lanes_of(n), 32'd0);
      chk($sformatf("rst_lanes_n%0d", n), 32'(lanes[n]), 32'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    logic took;
    int   nxt;
    do_reset();

    // N=4 back-to-back with open output
    step(4, 1, 8'h11, 0, 1, took);
    step(4, 1, 8'h22, 0, 1, took);
    step(4, 1, 8'h33, 0, 1, took);
    step(4, 1, 8'h44, 0, 1, took);
    step(4, 0, 8'h00, 0, 1, took);
    step(4, 0, 8'h00, 0, 1, took);

    // N=4 backpressure: first group held, closing word 8 stalls until release
    for (int w = 1; w <= 7; w++) step(4, 1, 8'(w), 0, 0, took);
    step(4, 1, 8'h08, 0, 0, took);
    step(4, 1, 8'h08, 0, 0, took);
    chk("n4_stall_word8", 32'(took), 32'd0);
    step(4, 1, 8'h08, 0, 1, took);
    chk("n4_word8_taken", 32'(took), 32'd1);
    step(4, 0, 8'h00, 0, 0, took);
    step(4, 0, 8'h00, 0, 1, took);
    step(4, 0, 8'h00, 0, 1, took);

    // N=2 stream 0..15 with random ready_out
    groups = 0;
    nxt = 0;
    for (int i = 0; i < 200 && nxt < 16; i++) begin
      step(2, 1, 8'(nxt), 0, 1'($urandom_range(0, 1)), took);
      if (took) nxt++;
    end
    chk("n2_all_sent", 32'(nxt), 32'd16);
    repeat (4) step(2, 0, 8'h00, 0, 1, took);
    chk("n2_groups", 32'(groups), 32'd8);

    // N=3: held group plus partial group discarded by reset
    for (int w = 1; w <= 5; w++) step(3, 1, 8'(w), 0, 0, took);
    do_reset();
    step(3, 1, 8'h0A, 0, 1, took);
    step(3, 1, 8'h0B, 0, 1, took);
    step(3, 1, 8'h0C, 0, 1, took);
    step(3, 0, 8'h00, 0, 0, took);
    step(3, 0, 8'h00, 0, 1, took);
    step(3, 0, 8'h00, 0, 1, took);

    // N=1 random register slice
    for (int i = 0; i < 40; i++)
      step(1, 1'($urandom_range(0, 1)), 8'($urandom), 0, 1'($urandom_range(0, 1)), took);
    repeat (3) step(1, 0, 8'h00, 0, 1, took);

`ifdef SERIAL_TO_PARALLEL_LAST_EN
    // N=4 early close, then a full group
    step(4, 1, 8'h10, 0, 1, took);
    step(4, 1, 8'h20, 1, 1, took);
    step(4, 0, 8'h00, 0, 0, took);
    step(4, 0, 8'h00, 0, 1, took);
    for (int w = 1; w <= 4; w++) step(4, 1, 8'(8'h30 + w), 0, 1, took);
    step(4, 0, 8'h00, 0, 0, took);
    step(4, 0, 8'h00, 0, 1, took);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
